spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- Responder side of the fetch path: services read requests, such as those issued by the playback flash controller on each fetch pulse, against an external SPI NOR flash.
- Issues standard READ (0x03) + 24-bit address in SPI mode 0, then streams 1–256 bytes back as a valid-only byte stream.
- Sits between the flash controller and the board flash pins; feeds the MP3 input buffer.

Parameters:
- ADDR_WIDTH, 24, flash byte address width (fixed 24 on the wire; must be ≤24).
- SCK_DIV, 2, clk cycles per SCK half-period (≥1).
- DESELECT_CYCLES, 4, minimum clk cycles cs_n held high between transactions (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  read request present.
- req_ready  out  1  block idle, able to accept.
- req_addr  in  ADDR_WIDTH  start byte address.
- req_len  in  8  byte count; 0 encodes 256.
- abort  in  1  terminate current transaction.
- data_out  out  8  received byte.
- data_valid  out  1  one-cycle strobe, data_out valid (no backpressure).
- busy  out  1  transaction in progress, including deselect.
- spi_sck  out  1  SPI clock, idle low.
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  SPI data to flash.
- spi_miso  in  1  SPI data from flash.

Behaviour:
- Reset (rst=0, async) values: req_ready=1, busy=0, data_valid=0, data_out=0, spi_cs_n=1, spi_sck=0, spi_mosi=0. The FSM returns to IDLE from any state, including mid-transfer.
- States: IDLE, CMD, ADDR, DATA, DESEL.
- Accept rule: handshake on a clk edge with req_valid&&req_ready (cycle 0). req_addr and req_len are latched. req_ready is high only in IDLE. Requests outside IDLE are ignored.
- Bit timing:
  - Bit k occupies cycles [1+2·SCK_DIV·k, 1+2·SCK_DIV·(k+1)).
  - spi_sck is low for the first SCK_DIV cycles of each bit and high for the second SCK_DIV cycles.
  - spi_mosi updates at the start of each bit, MSB first.
  - spi_miso is registered on the edge where spi_sck rises.
- CMD: cycle 1 drives spi_cs_n=0. Bits 0–7 = 0x03.
- ADDR: bits 8–31 = address, MSB first. Upper bits are zero-padded if ADDR_WIDTH<24.
- DATA:
  - Bits 32 onward; spi_mosi held 0.
  - Byte j (MSB first) completes at bit 39+8j. data_valid pulses in cycle 1+2·SCK_DIV·(40+8j).
  - With SCK_DIV=2: first byte at cycle 161, then one byte every 32 cycles.
- Last byte: in the same cycle as its data_valid, spi_cs_n goes high and spi_sck goes low; the FSM enters DESEL.
- DESEL: holds for DESELECT_CYCLES cycles, then IDLE with req_ready=1. busy stays high through DESEL.
- Address progression is by flash auto-increment only. Wrap past 0xFFFFFF is the flash's behaviour; the block does not track it.
- Byte counter is 9 bits; len 0 loads 256.
- abort:
  - Ignored in IDLE and DESEL.
  - In CMD/ADDR/DATA: the next cycle drives spi_cs_n=1 and spi_sck=0, and the FSM enters DESEL.
  - No data_valid is emitted after abort is sampled, including the case where a byte would complete in that same cycle. abort takes priority.
- data_out holds its last value between strobes.

Decomposition:
- Package flash_pkg:
  - CMD_READ=8'h03.
  - ADDR_BITS_WIRE=24.
  - state enum flash_rd_state_t.
  - LEN_ZERO_MEANS=256.
- Sub-module sck_gen: SCK_DIV half-period counter. Outputs sck, rise_pulse, bit_start_pulse; enable input.
- Shift registers and FSM live in spi_flash_reader.

Test Plan:
- Single byte: addr=0x012345, len=1, model returns 0xA5. Required response:
  - MOSI carries 0x03,0x01,0x23,0x45.
  - data_valid at cycle 161 with data_out=0xA5.
  - cs_n high at 161; req_ready back at 165.
- Burst: len=4, model returns 0x10..0x13. data_valid at cycles 161, 193, 225, 257 with data 0x10, 0x11, 0x12, 0x13; exactly 4 strobes.
- len=0: exactly 256 strobes; the last at cycle 1+4·(40+8·255)=8321.
- Abort: abort asserted during address bit 20 → cs_n high the next cycle, zero data_valid, req_ready after DESELECT_CYCLES. A new request then completes normally.
- Async reset mid-DATA (len=8, after byte 2) → cs_n=1, sck=0, req_ready=1 immediately; no further strobes.
- Back-to-back: req_valid held high with two addresses. Required response:
  - The second handshake occurs only after DESEL.
  - cs_n stays high ≥4 cycles between the two transactions.
  - The request presented while busy is not lost, since req_valid is held.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared constants and the state type for the SPI NOR flash read path.
//   CMD_READ        : standard single-lane READ opcode
//   ADDR_BITS_WIRE  : address bits always sent on the wire
//   LEN_ZERO_MEANS  : byte count that a request length of zero stands for
//   HDR_BITS        : opcode + address bits preceding the data phase
//   flash_rd_state_t: reader FSM states
package flash_pkg;

    localparam logic [7:0] CMD_READ       = 8'h03;
    localparam int         ADDR_BITS_WIRE = 24;
    localparam int         LEN_ZERO_MEANS = 256;
    localparam int         HDR_BITS       = 8 + ADDR_BITS_WIRE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DESEL
    } flash_rd_state_t;

endpackage

// File: rtl/sck_gen.sv
// SPI mode-0 clock generator. One bit period is 2*SCK_DIV clk cycles:
// SCK low for the first SCK_DIV cycles, high for the second SCK_DIV.
// Ports:
//   clk, rst        : system clock, asynchronous active-low reset
//   enable          : a transfer is running this cycle
//   clear           : the transfer stops at the coming edge; SCK forced low
//   sck             : registered SPI clock, idle low
//   rise_pulse      : the coming clk edge raises SCK (sample MISO there)
//   bit_start_pulse : the coming clk edge starts the next bit
module sck_gen #(
    parameter int SCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic sck,
    output logic rise_pulse,
    output logic bit_start_pulse
);

    localparam int CNT_W = (SCK_DIV > 1) ? $clog2(2 * SCK_DIV) : 1;
    localparam logic [CNT_W-1:0] RISE_AT   = CNT_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] HIGH_FROM = CNT_W'(SCK_DIV);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(2 * SCK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sck_reg, sck_next;

    // The counter parks at zero while idle so the first bit after enable
    // rises always starts with a full low phase.
    always_comb begin
        cnt_next = '0;
        sck_next = 1'b0;
        if (enable && !clear) begin
            cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CNT_W'(1);
            sck_next = (cnt_next >= HIGH_FROM);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            sck_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            sck_reg <= sck_next;
        end
    end

    assign sck             = sck_reg;
    assign rise_pulse      = enable && (cnt_reg == RISE_AT);
    assign bit_start_pulse = enable && (cnt_reg == LAST);

endmodule

// File: rtl/spi_flash_reader.sv
// Reads 1..256 bytes from an SPI NOR flash with the READ (0x03) command in
// SPI mode 0 and emits them as a valid-only byte stream.
// Ports:
//   clk, rst              : system clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_addr, req_len     : start byte address, byte count (0 = 256)
//   abort                 : stop the running transfer, no further bytes
//   data_out, data_valid  : received byte and its one-cycle strobe
//   busy                  : transfer or deselect gap in progress
//   spi_sck/cs_n/mosi/miso: flash pins
module spi_flash_reader
    import flash_pkg::*;
#(
    parameter int ADDR_WIDTH      = 24,
    parameter int SCK_DIV         = 2,
    parameter int DESELECT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_len,
    input  logic                  abort,
    output logic [7:0]            data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  spi_sck,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int               DES_W    = $clog2(DESELECT_CYCLES + 1);
    localparam logic [DES_W-1:0] DES_LOAD = DES_W'(DESELECT_CYCLES - 1);
    localparam logic [5:0]       CMD_LAST = 6'd7;
    localparam logic [5:0]       HDR_LAST = 6'(HDR_BITS - 1);

    flash_rd_state_t state_reg, state_next;
    logic [31:0]      tx_sr_reg, tx_sr_next;
    logic [5:0]       hdr_cnt_reg, hdr_cnt_next;
    logic [2:0]       bit_in_byte_reg, bit_in_byte_next;
    logic [7:0]       rx_sr_reg, rx_sr_next;
    logic [8:0]       left_reg, left_next;
    logic [DES_W-1:0] des_cnt_reg, des_cnt_next;
    logic             cs_n_reg, cs_n_next;
    logic             mosi_reg, mosi_next;
    logic [7:0]       data_out_reg, data_out_next;
    logic             data_valid_reg, data_valid_next;

    logic [ADDR_BITS_WIRE-1:0] addr_wire;
    logic active;
    logic leave;
    logic rise_pulse;
    logic bit_start_pulse;

    // Narrower addresses are zero-padded to the 24 wire bits.
    assign addr_wire = ADDR_BITS_WIRE'(req_addr);
    assign active    = (state_reg == ST_CMD) || (state_reg == ST_ADDR) ||
                       (state_reg == ST_DATA);

    sck_gen #(
        .SCK_DIV(SCK_DIV)
    ) u_sck_gen (
        .clk            (clk),
        .rst            (rst),
        .enable         (active),
        .clear          (leave),
        .sck            (spi_sck),
        .rise_pulse     (rise_pulse),
        .bit_start_pulse(bit_start_pulse)
    );

    always_comb begin
        state_next       = state_reg;
        tx_sr_next       = tx_sr_reg;
        hdr_cnt_next     = hdr_cnt_reg;
        bit_in_byte_next = bit_in_byte_reg;
        rx_sr_next       = rx_sr_reg;
        left_next        = left_reg;
        des_cnt_next     = des_cnt_reg;
        cs_n_next        = cs_n_reg;
        mosi_next        = mosi_reg;
        data_out_next    = data_out_reg;
        data_valid_next  = 1'b0;
        leave            = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next       = ST_CMD;
                    cs_n_next        = 1'b0;
                    // Bit 0 goes straight onto MOSI; the rest wait in the
                    // shift register, MSB first.
                    mosi_next        = CMD_READ[7];
                    tx_sr_next       = {CMD_READ[6:0], addr_wire, 1'b0};
                    hdr_cnt_next     = '0;
                    bit_in_byte_next = '0;
                    left_next        = (req_len == 8'd0) ? 9'(LEN_ZERO_MEANS)
                                                         : {1'b0, req_len};
                end
            end

            ST_CMD, ST_ADDR, ST_DATA: begin
                if (abort) begin
                    // Abort wins over a byte finishing in the same cycle.
                    leave = 1'b1;
                end else begin
                    if (rise_pulse && (state_reg == ST_DATA)) begin
                        rx_sr_next = {rx_sr_reg[6:0], spi_miso};
                    end
                    if (bit_start_pulse) begin
                        if (state_reg != ST_DATA) begin
                            mosi_next    = tx_sr_reg[31];
                            tx_sr_next   = {tx_sr_reg[30:0], 1'b0};
                            hdr_cnt_next = hdr_cnt_reg + 6'd1;
                            if (hdr_cnt_reg == CMD_LAST) begin
                                state_next = ST_ADDR;
                            end
                            if (hdr_cnt_reg == HDR_LAST) begin
                                state_next = ST_DATA;
                                mosi_next  = 1'b0;
                            end
                        end else begin
                            bit_in_byte_next = bit_in_byte_reg + 3'd1;
                            if (bit_in_byte_reg == 3'd7) begin
                                data_valid_next = 1'b1;
                                data_out_next   = rx_sr_reg;
                                left_next       = left_reg - 9'd1;
                                if (left_reg == 9'd1) begin
                                    leave = 1'b1;
                                end
                            end
                        end
                    end
                end
                if (leave) begin
                    state_next   = ST_DESEL;
                    cs_n_next    = 1'b1;
                    mosi_next    = 1'b0;
                    des_cnt_next = DES_LOAD;
                end
            end

            ST_DESEL: begin
                if (des_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    des_cnt_next = des_cnt_reg - DES_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                cs_n_next  = 1'b1;
                mosi_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            tx_sr_reg       <= '0;
            hdr_cnt_reg     <= '0;
            bit_in_byte_reg <= '0;
            rx_sr_reg       <= '0;
            left_reg        <= '0;
            des_cnt_reg     <= '0;
            cs_n_reg        <= 1'b1;
            mosi_reg        <= 1'b0;
            data_out_reg    <= '0;
            data_valid_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tx_sr_reg       <= tx_sr_next;
            hdr_cnt_reg     <= hdr_cnt_next;
            bit_in_byte_reg <= bit_in_byte_next;
            rx_sr_reg       <= rx_sr_next;
            left_reg        <= left_next;
            des_cnt_reg     <= des_cnt_next;
            cs_n_reg        <= cs_n_next;
            mosi_reg        <= mosi_next;
            data_out_reg    <= data_out_next;
            data_valid_reg  <= data_valid_next;
        end
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);
    assign spi_cs_n   = cs_n_reg;
    assign spi_mosi   = mosi_reg;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader with a behavioural SPI flash.
module tb_spi_flash_reader;

    localparam int D   = 2;
    localparam int DES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic        abort = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        busy;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    spi_flash_reader #(
        .ADDR_WIDTH(24),
        .SCK_DIV(D),
        .DESELECT_CYCLES(DES)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .abort(abort),
        .data_out(data_out), .data_valid(data_valid), .busy(busy),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference rules: strobe timing and flash contents (byte = addr[7:0] + seed).
    function automatic int strobe_cycle(input int j);
        return 1 + 2 * D * (40 + 8 * j);
    endfunction

    logic [7:0] seed = 8'h00;

    function automatic logic [7:0] model_byte(input logic [23:0] a, input int j, input logic [7:0] s);
        logic [23:0] x;
        x = a + 24'(j);
        return x[7:0] + s;
    endfunction

    // Behavioural flash: captures opcode+address on SCK rising, shifts data out on SCK falling.
    int          fl_bits = 0;
    logic [31:0] fl_hdr = '0;
    logic        sck_prev = 1'b0;
    always @(negedge clk) begin
        int k;
        logic [23:0] ad;
        logic [7:0] mb;
        if (spi_cs_n) begin
            fl_bits  = 0;
            spi_miso = 1'b0;
        end else if (spi_sck && !sck_prev) begin
            if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], spi_mosi};
            fl_bits++;
        end else if (!spi_sck && sck_prev && fl_bits >= 32) begin
            k        = fl_bits - 32;
            ad       = fl_hdr[23:0] + 24'(k / 8);
            mb       = ad[7:0] + seed;
            spi_miso = mb[7 - (k % 8)];
        end
        sck_prev = spi_cs_n ? 1'b0 : spi_sck;
    end

    // Monitor: cycle numbers are relative to the handshake cycle (cycle 0).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         hs_cyc = 0;
    int         hs_cnt = 0;
    int         hs_q[$];
    int         ready_rel = -1;
    int         csn_rel = -1;
    logic       busy_desel = 1'b0;
    int         hi_run = 0;
    int         last_hi_run = 0;
    int         st_rel[$];
    logic [7:0] st_dat[$];
    always @(negedge clk) begin
        int rel;
        if (req_valid && req_ready) begin
            hs_cyc = cyc;
            hs_cnt++;
            hs_q.push_back(cyc);
            ready_rel  = -1;
            csn_rel    = -1;
            busy_desel = 1'b0;
        end else begin
            rel = cyc - hs_cyc;
            if (rel >= 2 && spi_cs_n && csn_rel < 0) begin
                csn_rel    = rel;
                busy_desel = busy;
            end
            if (rel >= 1 && req_ready && ready_rel < 0) ready_rel = rel;
        end
        if (data_valid) begin
            st_rel.push_back(cyc - hs_cyc);
            st_dat.push_back(data_out);
        end
        if (spi_cs_n) hi_run++;
        else begin
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
        end
    end

    task automatic start_req(input logic [23:0] a, input logic [7:0] l, input bit drop);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; req_len = l;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin total++; bad++; $display("FAIL handshake_timeout addr=%0h", a); end
        @(posedge clk); #1;
        if (drop) req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (ready_rel >= 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin total++; bad++; $display("FAIL %s_timeout: got busy, required idle", tag); end
    endtask

    task automatic verify(input string tag, input logic [23:0] a, input int n, input int base,
                          input int exp_csn, input bit hdr_chk);
        check({tag, "_count"}, st_rel.size() - base, n);
        for (int j = 0; j < n && base + j < st_rel.size(); j++) begin
            check({tag, $sformatf("_cyc%0d", j)}, st_rel[base + j], strobe_cycle(j));
            check({tag, $sformatf("_dat%0d", j)}, st_dat[base + j], model_byte(a, j, seed));
        end
        check({tag, "_csn_high"}, csn_rel, exp_csn);
        check({tag, "_ready"}, ready_rel, exp_csn + DES);
        check({tag, "_busy_desel"}, busy_desel, 1);
        if (hdr_chk) check({tag, "_mosi_hdr"}, fl_hdr, {8'h03, a});
    endtask

    task automatic run_normal(input string tag, input logic [23:0] a, input logic [7:0] l,
                              input logic [7:0] s, output int base);
        int n;
        n    = (l == 0) ? 256 : int'(l);
        seed = s;
        base = st_rel.size();
        start_req(a, l, 1'b1);
        wait_done(tag, strobe_cycle(n) + 50);
        verify(tag, a, n, base, strobe_cycle(n - 1), 1'b1);
        $display("txn %s addr=%06h len=%0d strobes=%0d", tag, a, n, st_rel.size() - base);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        logic [7:0]  seed;
        int          exp_n;
        logic [7:0]  exp_first;
        int          exp_last_cyc;
        int          exp_ready;
    } vec_t;

    vec_t vecs[4];

    initial begin : main
        int base;
        int b2;
        int h0;
        bit ok;
        vecs[0] = '{24'h012345, 8'd1, 8'h60, 1, 8'hA5, 161, 165};
        vecs[1] = '{24'h000100, 8'd4, 8'h10, 4, 8'h10, 257, 261};
        vecs[2] = '{24'hFFFFFE, 8'd3, 8'h00, 3, 8'hFE, 225, 229};
        vecs[3] = '{24'h800000, 8'd2, 8'h5A, 2, 8'h5A, 193, 197};

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // abort while idle has no effect.
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("idle_abort_ready", req_ready, 1);
        check("idle_abort_cs_n", spi_cs_n, 1);

        // Table-driven vectors.
        for (int v = 0; v < 4; v++) begin
            run_normal($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].seed, base);
            if (st_rel.size() > base) begin
                check($sformatf("vec%0d_first_cyc", v), st_rel[base], 161);
                check($sformatf("vec%0d_first_dat", v), st_dat[base], vecs[v].exp_first);
            end
            if (st_rel.size() >= base + vecs[v].exp_n)
                check($sformatf("vec%0d_last_cyc", v), st_rel[base + vecs[v].exp_n - 1], vecs[v].exp_last_cyc);
            check($sformatf("vec%0d_ready_tbl", v), ready_rel, vecs[v].exp_ready);
        end

        // Randomized transactions against the reference rules.
        for (int r = 0; r < 6; r++) begin
            run_normal($sformatf("rnd%0d", r), 24'($urandom), 8'($urandom_range(1, 5)),
                       8'($urandom), base);
        end

        // len=0 means 256 bytes.
        run_normal("len0", 24'($urandom), 8'd0, 8'($urandom), base);
        if (st_rel.size() == base + 256) check("len0_last_cyc", st_rel[base + 255], 8321);

        // Abort during address bit 20 (cycles 81..84).
        seed = 8'h33;
        base = st_rel.size();
        start_req(24'hABCDEF, 8'd4, 1'b1);
        repeat (81) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_done("abort", 200);
        repeat (300) @(posedge clk);
        verify("abort", 24'hABCDEF, 0, base, 83, 1'b0);
        $display("txn abort addr=abcdef strobes=%0d csn_high=%0d", st_rel.size() - base, csn_rel);
        run_normal("after_abort", 24'h000042, 8'd2, 8'h07, base);

        // Asynchronous reset in the middle of the data phase (len=8, after 2 bytes).
        seed = 8'h21;
        base = st_rel.size();
        start_req(24'h123456, 8'd8, 1'b1);
        repeat (202) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_cs_n", spi_cs_n, 1);
        check("mid_rst_sck", spi_sck, 0);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data_out", data_out, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (300) @(posedge clk);
        check("mid_rst_count", st_rel.size() - base, 2);
        for (int j = 0; j < 2 && base + j < st_rel.size(); j++)
            check($sformatf("mid_rst_dat%0d", j), st_dat[base + j], model_byte(24'h123456, j, seed));
        $display("txn reset_mid_data addr=123456 strobes=%0d", st_rel.size() - base);

        // Back-to-back: req_valid held, second address presented while busy.
        seed = 8'h99;
        base = st_rel.size();
        h0   = hs_cnt;
        start_req(24'h0A0000, 8'd2, 1'b0);
        req_addr = 24'h0B0010;
        req_len  = 8'd1;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            if (hs_cnt >= h0 + 2) begin ok = 1'b1; break; end
        end
        if (!ok) begin total++; bad++; $display("FAIL b2b_second_hs: got %0d handshakes, required 2", hs_cnt - h0); end
        @(posedge clk); #1 req_valid = 1'b0;
        b2 = base + 2;
        wait_done("b2b", 400);
        repeat (10) @(posedge clk);
        check("b2b_hs_count", hs_cnt - h0, 2);
        if (hs_q.size() >= h0 + 2)
            check("b2b_hs_spacing", hs_q[h0 + 1] - hs_q[h0], strobe_cycle(1) + DES);
        check("b2b_gap_ge_des", last_hi_run >= DES, 1);
        for (int j = 0; j < 2 && base + j < st_rel.size(); j++)
            check($sformatf("b2b_first_dat%0d", j), st_dat[base + j], model_byte(24'h0A0000, j, seed));
        verify("b2b_second", 24'h0B0010, 1, b2, strobe_cycle(0), 1'b1);
        $display("txn back_to_back handshakes=%0d gap=%0d", hs_cnt - h0, last_hi_run);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
